// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel push-button debouncer.
//
// Contents:
//   deb_state_e  per-channel stability state (LOW, PEND_HI, HIGH, PEND_LO)
//   DEF_*        default parameter values used by debounce_channel and
//                multi_debouncer
//
// The encoding is chosen so that bit 1 of the state is the debounced
// level: HIGH and PEND_LO both report level=1.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'b00,
    PEND_HI = 2'b01,
    HIGH    = 2'b10,
    PEND_LO = 2'b11
  } deb_state_e;

  localparam int DEF_NUM_CH        = 5;
  localparam int DEF_STABLE_COUNT  = 5;
  localparam int DEF_CNT_W         = 3;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_REPEAT_DELAY  = 50;
  localparam int DEF_REPEAT_PERIOD = 10;

endpackage

// File: rtl/debounce_channel.sv
// Single debouncer channel: synchroniser chain, 4-state stability FSM,
// registered level and one-clock press / release pulses.
//
// Ports:
//   clk        system clock, posedge
//   reset      asynchronous, active-low reset
//   tick       sample enable; FSM and counters advance only when high
//   raw_in     raw asynchronous button pin
//   level      debounced level (registered)
//   press      1-clk pulse on accepted 0->1 (and each auto-repeat)
//   rel_pulse  1-clk pulse on accepted 1->0
//
// Optional feature: AUTO_REPEAT_EN adds a per-channel repeat counter that
// re-issues press while the button stays in HIGH.
//
// state   | meaning
// --------+---------------------------------------------------------
// LOW     | stable released, level=0
// PEND_HI | sampled 1 while LOW, counting consecutive 1 ticks
// HIGH    | stable pressed, level=1 (repeat counter runs if enabled)
// PEND_LO | sampled 0 while HIGH, counting consecutive 0 ticks
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT  = DEF_STABLE_COUNT,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic rel_pulse
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   s;

`ifdef AUTO_REPEAT_EN
  // Sized from the delay so the repeat counter never wraps, independent
  // of the stability counter width.
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  assign rpt_inc = rpt_q + RPT_W'(1);
`endif

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (tick) begin
      case (state_q)
        LOW: begin
          if (s) begin
            if (STABLE_COUNT == 1) begin
              state_d = HIGH;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = PEND_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TERM) begin
            state_d = HIGH;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            if (STABLE_COUNT == 1) begin
              state_d = LOW;
              cnt_d   = '0;
              rel_d   = 1'b1;
`ifdef AUTO_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              state_d = PEND_LO;
              cnt_d   = CNT_W'(1);
            end
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt_inc == RPT_W'(REPEAT_DELAY)) begin
            // Rewind by one period so later repeats hit the same terminal.
            press_d = 1'b1;
            rpt_d   = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
          end else begin
            rpt_d = rpt_inc;
          end
`endif
        end
        PEND_LO: begin
          // Repeat counter holds here; it resumes on return to HIGH.
          if (s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TERM) begin
            state_d = LOW;
            cnt_d   = '0;
            rel_d   = 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
    level_d = state_d[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
`ifdef AUTO_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign rel_pulse = rel_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer (up/down/left/right/fire).
//
// Ports:
//   clk        system clock, posedge
//   reset      asynchronous, active-low reset
//   tick       sample enable pulse (e.g. 100 Hz)
//   raw_in     raw button pins, one per channel
//   level      debounced level per channel
//   press      1-clk pulse per accepted press (and auto-repeat)
//   rel_pulse  1-clk pulse per accepted release
//   any_press  OR of press, same cycle
//
// Optional feature: AUTO_REPEAT_EN enables press auto-repeat
// (REPEAT_DELAY / REPEAT_PERIOD parameters exist only in that build).
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int STABLE_COUNT  = DEF_STABLE_COUNT,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] rel_pulse,
  output logic              any_press
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_COUNT  (STABLE_COUNT),
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (SYNC_STAGES)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .raw_in    (raw_in[g]),
      .level     (level[g]),
      .press     (press[g]),
      .rel_pulse (rel_pulse[g])
    );
  end

  // press is already registered, so the OR stays glitch-free and
  // clears asynchronously with reset.
  assign any_press = |press;

endmodule

// File: tb/tb_multi_debouncer.sv
module tb_multi_debouncer;

  localparam int NUM_CH = 5;
  localparam int SC     = 5;
  localparam int SYNC   = 2;
  localparam int RD     = 50;
  localparam int RP     = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic [NUM_CH-1:0] raw_in = '0;
  logic [NUM_CH-1:0] level, press, rel_pulse;
  logic              any_press;

  always #5 clk = ~clk;

  multi_debouncer dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .raw_in    (raw_in),
    .level     (level),
    .press     (press),
    .rel_pulse (rel_pulse),
    .any_press (any_press)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a button's accepted level flips once the synchronised
  // sample has disagreed with it on SC consecutive ticks.
  logic [NUM_CH-1:0] hist [SYNC];
  logic [NUM_CH-1:0] e_lvl = '0, e_press = '0, e_rel = '0;
  int                run  [NUM_CH];
  int                held [NUM_CH];
  logic [NUM_CH-1:0] seen_press, seen_rel;
  logic              seen_any;

  task automatic model_clear();
    for (int i = 0; i < SYNC; i++) hist[i] = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      run[c]  = 0;
      held[c] = 0;
    end
    e_lvl = '0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] s;
    e_press = '0;
    e_rel   = '0;
    if (!reset) begin
      model_clear();
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw_in;
      if (tick) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (s[c] != e_lvl[c]) begin
            run[c]++;
            if (run[c] == SC) begin
              run[c]   = 0;
              e_lvl[c] = ~e_lvl[c];
              if (e_lvl[c]) e_press[c] = 1'b1;
              else begin
                e_rel[c] = 1'b1;
                held[c]  = 0;
              end
            end
          end else begin
`ifdef AUTO_REPEAT_EN
            if (e_lvl[c] && run[c] == 0) begin
              held[c]++;
              if (held[c] == RD) begin
                e_press[c] = 1'b1;
                held[c]    = RD - RP;
              end
            end
`endif
            run[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic [NUM_CH-1:0] r, input logic t);
    raw_in = r;
    tick   = t;
    model_step();
    @(negedge clk);
    check_val("level", 32'(level), 32'(e_lvl));
    check_val("press", 32'(press), 32'(e_press));
    check_val("rel_pulse", 32'(rel_pulse), 32'(e_rel));
    check_val("any_press", 32'(any_press), 32'(|e_press));
    seen_press = seen_press | press;
    seen_rel   = seen_rel | rel_pulse;
    seen_any   = seen_any | any_press;
  endtask

  task automatic tick_unit(input logic [NUM_CH-1:0] r);
    cyc(r, 1'b1);
    repeat (3) cyc(r, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hits[$];
    int exp_hits[$];
    int any_units;
    logic [NUM_CH-1:0] r;

    model_clear();
    seen_press = '0;
    seen_rel   = '0;
    seen_any   = 1'b0;
    @(negedge clk);

    // 1: reset held with all buttons pressed, then release
    repeat (6) tick_unit(5'h1F);
    check_val("t1_rst_level", 32'(level), 32'h0);
    check_val("t1_rst_press", 32'(seen_press), 32'h0);
    reset = 1'b1;
    cyc(5'h1F, 1'b0);
    cyc(5'h1F, 1'b0);
    repeat (4) tick_unit(5'h1F);
    check_val("t1_early_level", 32'(level), 32'h0);
    check_val("t1_early_press", 32'(seen_press), 32'h0);
    tick_unit(5'h1F);
    check_val("t1_level", 32'(level), 32'h1F);
    check_val("t1_press", 32'(seen_press), 32'h1F);

    // 2: release all, then a 3-tick glitch on ch0, then a 4-tick one
    repeat (8) tick_unit(5'h00);
    check_val("t2_release", 32'(seen_rel), 32'h1F);
    seen_press = '0;
    repeat (3) tick_unit(5'h01);
    repeat (6) tick_unit(5'h00);
    check_val("t2_glitch_press", 32'(seen_press[0]), 32'h0);
    check_val("t2_glitch_level", 32'(level[0]), 32'h0);
    repeat (4) tick_unit(5'h01);
    repeat (6) tick_unit(5'h00);
    check_val("t2_cleared_press", 32'(seen_press[0]), 32'h0);

    // 3: ch2 held, then dropped
    repeat (8) tick_unit(5'h04);
    check_val("t3_level_hi", 32'(level), 32'h04);
    seen_press = '0;
    seen_rel   = '0;
    repeat (8) tick_unit(5'h00);
    check_val("t3_rel", 32'(seen_rel), 32'h04);
    check_val("t3_no_press", 32'(seen_press), 32'h0);
    check_val("t3_level_lo", 32'(level), 32'h0);

    // 4: tick stalled for 100 clocks with ch1 pressed
    seen_press = '0;
    repeat (100) cyc(5'h02, 1'b0);
    check_val("t4_hold_level", 32'(level), 32'h0);
    check_val("t4_hold_press", 32'(seen_press), 32'h0);
    n = 0;
    while (!seen_press[1] && n < 20) begin
      tick_unit(5'h02);
      n++;
    end
    check_val("t4_ticks", 32'(n), 32'd5);

    // 5: async reset while ch3 is pending high
    repeat (4) cyc(5'h0A, 1'b0);
    repeat (2) tick_unit(5'h0A);
    #2 reset = 1'b0;
    #1;
    check_val("t5_async_level", 32'(level), 32'h0);
    check_val("t5_async_press", 32'(press), 32'h0);
    check_val("t5_async_rel", 32'(rel_pulse), 32'h0);
    check_val("t5_async_any", 32'(any_press), 32'h0);
    cyc(5'h0A, 1'b0);
    cyc(5'h0A, 1'b1);
    reset = 1'b1;
    seen_press = '0;
    cyc(5'h0A, 1'b0);
    cyc(5'h0A, 1'b0);
    n = 0;
    while (seen_press == '0 && n < 20) begin
      tick_unit(5'h0A);
      n++;
    end
    check_val("t5_ticks", 32'(n), 32'd5);
    check_val("t5_press", 32'(seen_press), 32'h0A);

    // 6: ch4 held for 80 ticks
    repeat (8) tick_unit(5'h00);
    repeat (4) cyc(5'h10, 1'b0);
    exp_hits.push_back(5);
`ifdef AUTO_REPEAT_EN
    exp_hits.push_back(55);
    exp_hits.push_back(65);
    exp_hits.push_back(75);
`endif
    any_units = 0;
    for (int k = 1; k <= 80; k++) begin
      seen_press = '0;
      seen_any   = 1'b0;
      tick_unit(5'h10);
      if (seen_press[4]) hits.push_back(k);
      if (seen_any) any_units++;
    end
    check_val("t6_count", 32'(hits.size()), 32'(exp_hits.size()));
    check_val("t6_any_count", 32'(any_units), 32'(exp_hits.size()));
    for (int i = 0; i < exp_hits.size(); i++)
      check_val("t6_hit", (i < hits.size()) ? 32'(hits[i]) : 32'hFFFF_FFFF, 32'(exp_hits[i]));

    // Random phase: slow random toggling with bounce, random tick
    r = 5'h10;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 31) == 0) r[c] = ~r[c];
      cyc(r, ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
